mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, max consecutive data grants while a fetch waits.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 if_req  in  1  instruction fetch request; held until if_ack.
REQ-007 if_addr  in  ADDR_W  fetch address (PC); stable while if_req high.
REQ-008 if_flush  in  1  discard outstanding fetch (pipeline IF flush).
REQ-009 if_ack  out  1  one-cycle pulse, if_rdata valid.
REQ-010 if_rdata  out  DATA_W  fetched instruction.
REQ-011 d_req  in  1  data (MEM stage) request; held until d_ack.
REQ-012 d_we  in  1  1 = store, 0 = load; stable while d_req high.
REQ-013 d_addr  in  ADDR_W  data address.
REQ-014 d_wdata  in  DATA_W  store data.
REQ-015 d_ack  out  1  one-cycle pulse, access complete.
REQ-016 d_rdata  out  DATA_W  load data; valid with d_ack.
REQ-017 mem_req  out  1  request to shared single-port memory.
REQ-018 mem_we  out  1  write enable to memory.
REQ-019 mem_addr  out  ADDR_W  memory address.
REQ-020 mem_wdata  out  DATA_W  memory write data.
REQ-021 mem_ack  in  1  one-cycle memory completion, 1+ cycles after mem_req rises.
REQ-022 mem_rdata  in  DATA_W  read data, valid with mem_ack.
REQ-023 stall_if  out  1  = if_req & ~if_ack (drives PCWrite hold).
REQ-024 stall_mem  out  1  = d_req & ~d_ack (freezes pipeline).
REQ-025 err  out  1  sticky: mem_ack received outside BUSY state.

Function
REQ-026 FSM SHALL have states IDLE, BUSY_IF, BUSY_D.
REQ-027 IDLE: eligible requester = req high and its ack not high this cycle.
REQ-028 IDLE arbitration: d wins; exception: if starve_cnt == STARVE_MAX and if eligible, if wins.
REQ-029 On grant, SHALL register addr/we/wdata (if grant: we=0, wdata=0) and enter BUSY_x next cycle.
REQ-030 mem_req, mem_we, mem_addr, mem_wdata SHALL be driven from registers, high/valid only in BUSY_IF/BUSY_D, constant throughout.
REQ-031 BUSY_x with mem_ack: register mem_rdata into x_rdata, pulse x_ack next cycle, return to IDLE.
REQ-032 Minimum latency: req sampled at edge N -> mem_req at cycle N+1 -> x_ack at cycle N+2 when mem_ack at N+1.
REQ-033 starve_cnt: +1 on d grant while if_req high (saturate STARVE_MAX); cleared on if grant or when if_req low in IDLE.
REQ-034 if_flush high in BUSY_IF or in the mem_ack cycle SHALL set a drop flag; transaction completes on memory, if_ack suppressed, if_rdata unchanged.
REQ-035 if_flush in IDLE or BUSY_D SHALL have no effect.
REQ-036 mem_ack in IDLE SHALL set err and be otherwise ignored.
REQ-037 if_ack and d_ack SHALL never be high in the same cycle.
REQ-038 if_rdata/d_rdata SHALL hold last value between acks.

Reset
REQ-039 rst SHALL force IDLE, starve_cnt 0, drop flag 0, err 0, all outputs 0 on next edge.
REQ-040 rst mid-transaction SHALL abandon it; no ack issued; memory shares rst.

Structure
REQ-041 State enum and default parameter constants SHALL live in shared package mem_arb_pkg.
REQ-042 Starvation counter SHALL be sub-module starve_counter; rest single module.

Verification
REQ-043 d_req store 0x10 <- 0xDEADBEEF, mem_ack 1 cycle later -> mem_we=1, d_ack at cycle N+2, if idle.
REQ-044 if_req and d_req same edge -> BUSY_D first; if granted after d_ack; stall_if high throughout.
REQ-045 if_req held, d_req back-to-back 6 times, STARVE_MAX=4 -> 4 d grants, then if grant, then d.
REQ-046 if_req 0x40, if_flush in BUSY_IF, mem_ack 3 cycles later -> no if_ack, state IDLE, next fetch served.
REQ-047 mem_ack pulsed in IDLE -> err=1 until rst; rst during BUSY_D -> mem_req=0, no d_ack.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared state encoding and default parameter values for the instruction/data
// memory arbiter and its starvation counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } arb_state_e;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_STARVE_MAX = 4;

    // Counter width able to hold 0..max, never narrower than one bit.
    function automatic int cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating count of data grants issued while an instruction fetch waits;
// sat tells the arbiter that the fetch must win the next arbitration.
module starve_counter
    import mem_arb_pkg::*;
#(
    parameter int MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic sat
);

    localparam int W = cnt_width(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != W'(MAX))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat = (cnt_q == W'(MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-port
// memory; data has priority unless the fetch has been starved too long.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              err
);

    arb_state_e        state_q,     state_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q,    if_ack_d;
    logic              d_ack_q,     d_ack_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
    logic              drop_q,      drop_d;
    logic              err_q,       err_d;

    logic if_elig, d_elig, arb_open, grant_if, grant_d;
    logic starve_sat, starve_clr, starve_inc;

    // A requester still holds req during its ack cycle, so that cycle is a
    // turnaround: nobody is granted until it can present its next request.
    assign if_elig  = if_req && !if_ack_q;
    assign d_elig   = d_req && !d_ack_q;
    assign arb_open = (state_q == IDLE) && !if_ack_q && !d_ack_q;
    assign grant_if = arb_open && if_elig && (starve_sat || !d_elig);
    assign grant_d  = arb_open && d_elig && !(starve_sat && if_elig);

    assign starve_clr = grant_if || ((state_q == IDLE) && !if_req);
    assign starve_inc = grant_d && if_req;

    starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk (clk),
        .rst (rst),
        .clr (starve_clr),
        .inc (starve_inc),
        .sat (starve_sat)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        drop_d      = drop_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (mem_ack) begin
                    err_d = 1'b1;
                end
                if (grant_d) begin
                    state_d     = BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end else if (grant_if) begin
                    state_d     = BUSY_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    drop_d      = 1'b0;
                end
            end
            BUSY_IF: begin
                if (if_flush) begin
                    drop_d = 1'b1;
                end
                // A flushed fetch still finishes on the memory but is never acked.
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    drop_d    = 1'b0;
                    if (!(drop_q || if_flush)) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            BUSY_D: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    d_ack_d   = 1'b1;
                    d_rdata_d = mem_rdata;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            drop_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            drop_q      <= drop_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign err       = err_q;
    assign stall_if  = if_req && !if_ack_q;
    assign stall_mem = d_req && !d_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic checked against a shadow memory and a starvation bound.
module tb_mem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req, if_flush, if_ack;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req, d_we, d_ack;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata, d_rdata;
    logic              mem_req, mem_we, mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              stall_if, stall_mem, err;

    mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory environment and reference state
    logic [31:0] env_mem [logic [31:0]];
    logic [31:0] shadow  [logic [31:0]];
    bit  mem_auto, mem_rand, mem_busy;
    int  mem_lat, mem_wait, env_acks;
    int  ack_log[$];

    // Random-phase agent state
    bit  rand_mode, gen_on;
    int  d_while_if, n_if_rand, n_d_rand;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] env_read(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] shadow_read(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : init_word(a);
    endfunction

    function automatic int log_at(input int k);
        return (k < ack_log.size()) ? ack_log[k] : 0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: wait for the falling edge, then play memory and (optionally) random requesters.
    task automatic step();
        @(negedge clk);
        if (if_ack) ack_log.push_back(1);
        if (d_ack)  ack_log.push_back(2);
        if (if_ack || d_ack) check("ack_exclusive", 64'(if_ack && d_ack), 64'd0);

        if (mem_auto) begin
            mem_ack = 1'b0;
            if (!mem_req) begin
                mem_busy = 1'b0;
            end else begin
                if (!mem_busy) begin
                    mem_busy = 1'b1;
                    mem_wait = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
                end
                if (mem_wait == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = env_read(mem_addr);
                    if (mem_we) env_mem[mem_addr] = mem_wdata;
                    env_acks++;
                    mem_wait  = -1;
                end else if (mem_wait > 0) begin
                    mem_wait--;
                end
            end
        end

        if (rand_mode) begin
            if (if_ack) begin
                check("rand_if_data", 64'(if_rdata), 64'(init_word(if_addr)));
                check("rand_if_starve", 64'(d_while_if <= STARVE_MAX + 1), 64'd1);
                if_req = 1'b0;
                n_if_rand++;
            end
            if (d_ack) begin
                if (if_req) d_while_if++;
                if (d_we) shadow[d_addr] = d_wdata;
                else check("rand_d_data", 64'(d_rdata), 64'(shadow_read(d_addr)));
                d_req = 1'b0;
                n_d_rand++;
            end
            if (gen_on && !if_req && $urandom_range(0, 3) == 0) begin
                if_req     = 1'b1;
                if_addr    = 32'h1000 + 32'($urandom_range(0, 63)) * 4;
                d_while_if = 0;
            end
            if (gen_on && !d_req && $urandom_range(0, 2) == 0) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 32'h2000 + 32'($urandom_range(0, 7)) * 4;
                d_wdata = $urandom;
            end
        end
    endtask

    task automatic wait_d_ack(input string tag);
        int n = 0;
        do begin step(); n++; end while (!d_ack && n < 50);
        check(tag, 64'(d_ack), 64'd1);
    endtask

    task automatic wait_if_ack(input string tag);
        int n = 0;
        do begin step(); n++; end while (!if_ack && n < 50);
        check(tag, 64'(if_ack), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n, dn;
        bit  stall_ok, saw, if_done;
        int  env_before;

        rst = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        mem_auto = 1'b1; mem_rand = 1'b0; mem_busy = 1'b0; mem_lat = 0; mem_wait = -1; env_acks = 0;
        rand_mode = 1'b0; gen_on = 1'b0; d_while_if = 0; n_if_rand = 0; n_d_rand = 0;

        // Reset state
        repeat (3) step();
        check("rst_mem_req",   64'(mem_req),   64'd0);
        check("rst_mem_we",    64'(mem_we),    64'd0);
        check("rst_mem_addr",  64'(mem_addr),  64'd0);
        check("rst_if_ack",    64'(if_ack),    64'd0);
        check("rst_d_ack",     64'(d_ack),     64'd0);
        check("rst_if_rdata",  64'(if_rdata),  64'd0);
        check("rst_d_rdata",   64'(d_rdata),   64'd0);
        check("rst_err",       64'(err),       64'd0);
        check("rst_stall_if",  64'(stall_if),  64'd0);
        check("rst_stall_mem", 64'(stall_mem), 64'd0);
        rst = 1'b0;
        step();

        // Store with minimum latency, fetch port idle
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
        step();
        check("st_mem_req",   64'(mem_req),   64'd1);
        check("st_mem_we",    64'(mem_we),    64'd1);
        check("st_mem_addr",  64'(mem_addr),  64'h10);
        check("st_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        check("st_no_ack_n1", 64'(d_ack),     64'd0);
        check("st_stall_mem", 64'(stall_mem), 64'd1);
        step();
        check("st_d_ack_n2",  64'(d_ack),     64'd1);
        check("st_if_ack",    64'(if_ack),    64'd0);
        check("st_mem_drop",  64'(mem_req),   64'd0);
        check("st_stall_off", 64'(stall_mem), 64'd0);
        d_req = 1'b0; d_we = 1'b0;
        step();
        d_req = 1'b1; d_addr = 32'h10;
        wait_d_ack("ld_ack");
        check("ld_rdata", 64'(d_rdata), 64'hDEAD_BEEF);
        d_req = 1'b0;
        step();

        // Simultaneous requests: data first, fetch after the data ack
        ack_log.delete();
        mem_lat = 1;
        if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        step();
        check("both_first_addr", 64'(mem_addr), 64'h20);
        check("both_first_we",   64'(mem_we),   64'd0);
        check("both_stall_if",   64'(stall_if), 64'd1);
        stall_ok = 1'b1; n = 0;
        while (!if_ack && n < 60) begin
            step(); n++;
            if (d_ack) begin
                check("both_d_rdata", 64'(d_rdata), 64'(init_word(32'h20)));
                d_req = 1'b0;
            end
            if (!if_ack && stall_if !== 1'b1) stall_ok = 1'b0;
        end
        check("both_if_ack",     64'(if_ack),   64'd1);
        check("both_stall_kept", 64'(stall_ok), 64'd1);
        check("both_if_rdata",   64'(if_rdata), 64'(init_word(32'h100)));
        check("both_stall_off",  64'(stall_if), 64'd0);
        check("both_order_len",  64'(ack_log.size()), 64'd2);
        check("both_order_0",    64'(log_at(0)), 64'd2);
        check("both_order_1",    64'(log_at(1)), 64'd1);
        if_req = 1'b0;
        step();

        // Starvation: fetch held against six back-to-back loads
        ack_log.delete();
        mem_lat = 0;
        if_req = 1'b1; if_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
        dn = 0; if_done = 1'b0;
        for (int k = 0; k < 300 && !(dn == 6 && if_done); k++) begin
            step();
            if (if_ack) begin if_req = 1'b0; if_done = 1'b1; end
            if (d_ack) begin
                dn++;
                if (dn < 6) d_addr = 32'h30 + 32'(dn) * 4;
                else d_req = 1'b0;
            end
        end
        check("starve_done", 64'(dn == 6 && if_done), 64'd1);
        check("starve_len",  64'(ack_log.size()), 64'd7);
        for (int k = 0; k < 7; k++) begin
            check($sformatf("starve_order%0d", k), 64'(log_at(k)), (k == STARVE_MAX) ? 64'd1 : 64'd2);
        end
        check("starve_if_rdata", 64'(if_rdata), 64'(init_word(32'h200)));
        step(); step();

        // Fetch flushed while the memory is busy
        mem_lat = 3; env_before = env_acks;
        if_req = 1'b1; if_addr = 32'h40;
        step();
        check("flush_busy_req",  64'(mem_req),  64'd1);
        check("flush_busy_addr", 64'(mem_addr), 64'h40);
        if_flush = 1'b1; if_req = 1'b0;
        step();
        saw = if_ack;
        if_flush = 1'b0;
        repeat (8) begin step(); if (if_ack) saw = 1'b1; end
        check("flush_no_ack",    64'(saw),      64'd0);
        check("flush_idle",      64'(mem_req),  64'd0);
        check("flush_mem_done",  64'(env_acks - env_before), 64'd1);
        check("flush_rdata_hold", 64'(if_rdata), 64'(init_word(32'h200)));
        mem_lat = 0;
        if_req = 1'b1; if_addr = 32'h44;
        wait_if_ack("refetch_ack");
        check("refetch_rdata", 64'(if_rdata), 64'(init_word(32'h44)));
        if_req = 1'b0;
        step();

        // Flush arriving in the same cycle as mem_ack
        mem_lat = 2; saw = 1'b0;
        if_req = 1'b1; if_addr = 32'h4C;
        for (int k = 0; k < 10; k++) begin
            step();
            if (if_ack) saw = 1'b1;
            if (mem_ack) begin if_flush = 1'b1; if_req = 1'b0; end
            else if_flush = 1'b0;
        end
        if_flush = 1'b0;
        check("flush_ack_cycle_no_ack", 64'(saw),      64'd0);
        check("flush_ack_cycle_hold",   64'(if_rdata), 64'(init_word(32'h44)));
        mem_lat = 0;

        // Flush in IDLE and during a data access has no effect
        if_req = 1'b1; if_addr = 32'h48; if_flush = 1'b1;
        step();
        if_flush = 1'b0;
        if (!if_ack) wait_if_ack("flush_idle_ack");
        check("flush_idle_rdata", 64'(if_rdata), 64'(init_word(32'h48)));
        if_req = 1'b0;
        step();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; if_flush = 1'b1;
        wait_d_ack("flush_d_ack");
        check("flush_d_rdata", 64'(d_rdata), 64'hDEAD_BEEF);
        d_req = 1'b0; if_flush = 1'b0;
        step(); step();

        // Stray mem_ack in IDLE sets sticky err
        mem_auto = 1'b0;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("err_set", 64'(err), 64'd1);
        repeat (3) step();
        check("err_sticky",   64'(err),     64'd1);
        check("err_no_req",   64'(mem_req), 64'd0);
        check("err_no_d_ack", 64'(d_ack),   64'd0);
        mem_auto = 1'b1;

        // Reset during BUSY_D abandons the access
        mem_lat = 5;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14;
        step();
        check("rstd_busy",      64'(mem_req), 64'd1);
        check("rstd_err_still", 64'(err),     64'd1);
        rst = 1'b1; d_req = 1'b0;
        step();
        check("rstd_mem_req", 64'(mem_req), 64'd0);
        check("rstd_d_ack",   64'(d_ack),   64'd0);
        check("rstd_err_clr", 64'(err),     64'd0);
        rst = 1'b0; saw = 1'b0;
        repeat (8) begin step(); if (d_ack || mem_req) saw = 1'b1; end
        check("rstd_quiet", 64'(saw), 64'd0);

        // Random traffic against the shadow memory
        mem_rand = 1'b1; rand_mode = 1'b1; gen_on = 1'b1;
        repeat (600) step();
        gen_on = 1'b0;
        n = 0;
        while ((if_req || d_req) && n < 300) begin step(); n++; end
        check("rand_drain",    64'(if_req || d_req), 64'd0);
        check("rand_activity", 64'(n_if_rand > 0 && n_d_rand > 0), 64'd1);
        check("rand_err",      64'(err), 64'd0);
        rand_mode = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
